// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receive path.
//
// Holds the receiver FSM state encoding and the default timing parameters
// (50 MHz clock, 115200 baud). The optional even-parity frame format is
// selected at build time with `define UART_RX_PARITY_EN; the ST_PARITY state
// exists in the encoding either way but is only reachable when that macro is
// defined.

package uart_rx_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int DEFAULT_SYNC_STAGES  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_sync: multi-flop synchroniser for an asynchronous level input.
//
// The chain presets to 1 on reset so an idle-high line (such as a UART rx
// pin) does not look like an edge as reset is released.
//
// Ports:
//   clk  in  1  system clock
//   rst  in  1  synchronous, active-high reset (chain presets to all ones)
//   d    in  1  asynchronous input
//   q    out 1  synchronised copy of d, STAGES cycles late

module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw input through the flop chain; the first flop may go
   // metastable, the later ones give it time to resolve.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '1;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 frames from the rx pin into bytes on a
// valid/ready handshake towards the command decoder.
//
// Build option: `define UART_RX_PARITY_EN switches the frame to 8E1 and adds
// the parity_err output port.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (8..65535), default 434
//   SYNC_STAGES   depth of the rx synchroniser (2..3), default 2
//
// Ports:
//   clk        in  1  system clock, rising edge
//   rst        in  1  synchronous, active-high reset
//   rx         in  1  serial input, idles high, asynchronous to clk
//   data       out 8  received byte (LSB first on the wire), held while valid
//   valid      out 1  data holds an unconsumed byte
//   ready      in  1  consumer takes data when valid && ready
//   frame_err  out 1  one-cycle pulse: stop bit sampled low
//   overrun    out 1  sticky: a good byte was dropped because valid was high
//   busy       out 1  receiver is inside a frame
//   parity_err out 1  (parity build only) one-cycle pulse: parity mismatch

module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  FULL_LOAD = CW'(CLKS_PER_BIT - 1);

   rx_state_t     state;
   rx_state_t     next_state;
   logic          rx_s;
   logic          rx_prev;
   logic [CW-1:0] cnt;
   logic          tick;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          parity_ok;

   logic          load_half;
   logic          load_full;
   logic          sample_data;
   logic          frame_good;
   logic          frame_bad;
   logic          parity_bad;
`ifdef UART_RX_PARITY_EN
   logic          sample_parity;
`endif

   uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign tick = (cnt == '0);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A start is only taken on a genuine 1->0 edge of rx_s,
   // so a line held low after a broken frame keeps the FSM in IDLE until it
   // has gone high again. STOP returns to IDLE at the stop-bit centre, which
   // leaves half a bit to catch the next start edge of a back-to-back frame.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (rx_prev && !rx_s) next_state = ST_START;
         ST_START:  if (tick) next_state = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA: begin
            if (tick && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
               next_state = ST_PARITY;
`else
               next_state = ST_STOP;
`endif
            end
         end
         ST_PARITY: if (tick) next_state = ST_STOP;
         ST_STOP:   if (tick) next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Output / strobe decode from the current state. The half-bit load
   // centres every later sample in its bit; after that each bit-centre
   // event reloads a full bit period.
   always_comb begin
      busy        = (state != ST_IDLE);
      load_half   = (state == ST_IDLE) && rx_prev && !rx_s;
      load_full   = tick && (((state == ST_START) && !rx_s) ||
                             (state == ST_DATA) || (state == ST_PARITY));
      sample_data = (state == ST_DATA) && tick;
      frame_good  = (state == ST_STOP) && tick && rx_s && parity_ok;
      frame_bad   = (state == ST_STOP) && tick && !rx_s;
      parity_bad  = (state == ST_STOP) && tick && rx_s && !parity_ok;
`ifdef UART_RX_PARITY_EN
      sample_parity = (state == ST_PARITY) && tick;
`endif
   end

   // Bit-period counter and edge-detect history of the synchronised line.
   // The counter parks at zero once a frame ends or a start is rejected.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         rx_prev <= 1'b1;
      end else begin
         rx_prev <= rx_s;
         if (load_half) begin
            cnt <= HALF_LOAD;
         end else if (load_full) begin
            cnt <= FULL_LOAD;
         end else if ((state != ST_IDLE) && !tick) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // Data shift register: bits arrive LSB first, so each new bit enters at
   // the top and the byte is aligned after the eighth sample. The bit index
   // wraps 7->0 on that last sample, ready for the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift   <= 8'h00;
         bit_idx <= 3'd0;
      end else if (sample_data) begin
         shift   <= {rx_s, shift[7:1]};
         bit_idx <= bit_idx + 3'd1;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Even parity: the parity bit must equal the XOR of the data bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_ok <= 1'b1;
      end else if (load_half) begin
         parity_ok <= 1'b1;
      end else if (sample_parity) begin
         parity_ok <= ((^shift) == rx_s);
      end
   end
`else
   assign parity_ok = 1'b1;
`endif

   // Output holding register. A good byte loads if the slot is free or is
   // being emptied on this same cycle; otherwise it is dropped and overrun
   // latches until reset. Broken frames never touch data or valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= frame_bad;
         if (frame_good) begin
            if (!valid || ready) begin
               data  <= shift;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= parity_bad;
      end
   end
`else
   // Without parity a stop-good frame is always good, so parity_bad is
   // constant low; fold it in so the decode stays shared between builds.
   logic unused_parity;
   assign unused_parity = parity_bad;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 434 clocks per bit.
//
// Bytes expected from the receiver are queued as frames are sent; a monitor
// on the falling clock edge pops and compares on every valid && ready
// handshake and counts frame_err / parity_err pulse cycles. Build with
// `define UART_RX_PARITY_EN to exercise the 8E1 variant.

module tb_uart_rx;

   localparam int CPB = 434;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int         total = 0;
   int         bad   = 0;
   int         fe_cnt = 0;
   int         pe_cnt = 0;
   int         fe_before;
   logic [7:0] exp_q[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   // One comparison: counts it, and reports it when the values differ.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Hold one bit level for a full bit period; leaves time at posedge+1.
   task automatic driveBit(input logic v);
      rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Send one frame: start, 8 data bits LSB first, optional parity, stop.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                                input logic flip_par);
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(b[i]);
`ifdef UART_RX_PARITY_EN
      driveBit((^b) ^ flip_par);
`else
      if (flip_par) $display("[TB] parity flip ignored in 8N1 build");
`endif
      driveBit(stop_bit);
      rx = 1'b1;
   endtask

   task automatic idleBits(input int n);
      rx = 1'b1;
      repeat (n * CPB) @(posedge clk);
      #1;
   endtask

   task automatic waitDrain(input string name, input int budget);
      for (int i = 0; (i < budget) && (exp_q.size() != 0); i++) @(posedge clk);
      #1;
      checkOutput(name, exp_q.size(), 0);
   endtask

   // Scoreboard monitor: every accepted byte must match the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected byte: got %0h, expected none", data);
            end else begin
               checkOutput("rx byte", data, exp_q.pop_front());
            end
         end
         if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
         if (parity_err) pe_cnt++;
`endif
      end
   end

   initial begin
      rst   = 1'b1;
      rx    = 1'b1;
      ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("reset data", data, 8'h00);
      checkOutput("reset valid", valid, 0);
      checkOutput("reset frame_err", frame_err, 0);
      checkOutput("reset overrun", overrun, 0);
      checkOutput("reset busy", busy, 0);
      rst = 1'b0;
      idleBits(2);

      // Single frame
      exp_q.push_back(8'hA5);
      applyStimulus(8'hA5, 1'b1, 1'b0);
      waitDrain("A5 drained", 2 * CPB);
      checkOutput("A5 frame_err count", fe_cnt, 0);
      idleBits(1);

      // Back-to-back frames with no idle time between them
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      applyStimulus(8'h00, 1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b1, 1'b0);
      waitDrain("00/FF drained", 2 * CPB);
      checkOutput("00/FF overrun", overrun, 0);
      idleBits(1);

      // Overrun: consumer stalls, second byte is dropped
      ready = 1'b0;
      exp_q.push_back(8'h3C);
      applyStimulus(8'h3C, 1'b1, 1'b0);
      applyStimulus(8'hC3, 1'b1, 1'b0);
      idleBits(1);
      checkOutput("overrun valid held", valid, 1);
      checkOutput("overrun data held", data, 8'h3C);
      checkOutput("overrun flag", overrun, 1);
      ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("valid drops after accept", valid, 0);
      waitDrain("3C drained", 4);
      checkOutput("overrun sticky", overrun, 1);

      // Framing error, then a clean frame
      fe_before = fe_cnt;
      applyStimulus(8'h55, 1'b0, 1'b0);
      idleBits(2);
      checkOutput("55 frame_err pulses", fe_cnt - fe_before, 1);
      checkOutput("55 valid", valid, 0);
      exp_q.push_back(8'h12);
      applyStimulus(8'h12, 1'b1, 1'b0);
      waitDrain("12 drained", 2 * CPB);
      idleBits(1);

      // 100-cycle glitch from idle
      fe_before = fe_cnt;
      rx = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      checkOutput("glitch busy during", busy, 1);
      repeat (50) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (CPB / 2 + 10) @(posedge clk);
      #1;
      checkOutput("glitch busy after", busy, 0);
      checkOutput("glitch valid", valid, 0);
      checkOutput("glitch frame_err", fe_cnt - fe_before, 0);
      idleBits(1);

      // Reset in the middle of 8'h81, at bit 4
      driveBit(1'b0);
      for (int i = 0; i < 4; i++) driveBit(i == 0);
      rx = 1'b0;
      repeat (CPB / 2) @(posedge clk);
      #1;
      checkOutput("mid-frame busy", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid rst data", data, 8'h00);
      checkOutput("mid rst valid", valid, 0);
      checkOutput("mid rst overrun", overrun, 0);
      checkOutput("mid rst frame_err", frame_err, 0);
      checkOutput("mid rst busy", busy, 0);
      rst = 1'b0;
      idleBits(2);
      exp_q.push_back(8'h7E);
      applyStimulus(8'h7E, 1'b1, 1'b0);
      waitDrain("7E drained", 2 * CPB);
      checkOutput("7E overrun", overrun, 0);
      idleBits(1);

`ifdef UART_RX_PARITY_EN
      // Wrong parity bit: byte discarded with a parity_err pulse
      applyStimulus(8'h07, 1'b1, 1'b1);
      idleBits(1);
      checkOutput("07 parity_err pulses", pe_cnt, 1);
      checkOutput("07 valid", valid, 0);
`endif

      checkOutput("scoreboard empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
